// File: rtl/loader_pkg.sv
// Shared types and constants for the UART program loader.
// Optional checksum stage is enabled by defining LOADER_CHECKSUM_EN.
package loader_pkg;

    localparam int BYTE_W             = 8;
    localparam int DEFAULT_WORD_BYTES = 4;
    localparam int DEFAULT_DEPTH      = 32;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_CSUM = 3'd2,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } loader_state_e;
    localparam loader_state_e ST_AFTER_PAYLOAD = ST_CSUM;
`else
    typedef enum logic [2:0] {
        ST_LEN  = 3'd0,
        ST_DATA = 3'd1,
        ST_DONE = 3'd3,
        ST_ERR  = 3'd4
    } loader_state_e;
    localparam loader_state_e ST_AFTER_PAYLOAD = ST_DONE;
`endif

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    // Counter width able to hold values 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling, one-cycle
// rx_valid pulse per good byte and rx_ferr pulse on a low stop bit.
module uart_rx
    import loader_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 2604
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                rxd,
    output logic [BYTE_W-1:0]   rx_data,
    output logic                rx_valid,
    output logic                rx_ferr
);

    localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
    localparam int CW      = cnt_width(BIT_CYC);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLK_PER_HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(BIT_CYC - 1);

    logic              sync1_q, sync2_q, prev_q;
    rx_state_e         st_q, st_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] sh_q, sh_d;
    logic [BYTE_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic              ferr_q, ferr_d;

    // Synchroniser and edge-history flops; idle line is high.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Bit-timing state machine next-state logic.
    always_comb begin
        st_d    = st_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        sh_d    = sh_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        case (st_q)
            RX_IDLE: begin
                if (prev_q && !sync2_q) begin
                    st_d  = RX_START;
                    cnt_d = HALF_M1;
                end else begin
                    st_d = RX_IDLE;
                end
            end
            RX_START: begin
                if (cnt_q == CW'(0)) begin
                    // A start bit that is high again at mid-bit was a glitch.
                    if (!sync2_q) begin
                        st_d  = RX_DATA;
                        cnt_d = BIT_M1;
                        bit_d = 3'd0;
                    end else begin
                        st_d = RX_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_DATA: begin
                if (cnt_q == CW'(0)) begin
                    sh_d  = {sync2_q, sh_q[BYTE_W-1:1]};
                    cnt_d = BIT_M1;
                    if (bit_q == 3'd7) begin
                        st_d = RX_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RX_STOP: begin
                if (cnt_q == CW'(0)) begin
                    st_d = RX_IDLE;
                    if (sync2_q) begin
                        valid_d = 1'b1;
                        data_d  = sh_q;
                    end else begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                st_d = RX_IDLE;
            end
        endcase
    end

    // Receiver state and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            st_q    <= RX_IDLE;
            cnt_q   <= CW'(0);
            bit_q   <= 3'd0;
            sh_q    <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            st_q    <= st_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    assign rx_data  = data_q;
    assign rx_valid = valid_q;
    assign rx_ferr  = ferr_q;

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed little-endian program from UART into instruction
// memory, then releases the core. Define LOADER_CHECKSUM_EN for a trailing XOR byte.
module program_loader
    import loader_pkg::*;
#(
    parameter int CLK_PER_HALF_BIT = 2604,
    parameter int DEPTH            = DEFAULT_DEPTH,
    parameter int WORD_BYTES       = DEFAULT_WORD_BYTES
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         rxd,
    output logic                         imem_we,
    output logic [$clog2(DEPTH)-1:0]     imem_addr,
    output logic [BYTE_W*WORD_BYTES-1:0] imem_wdata,
    output logic                         core_rstn,
    output logic                         load_done,
    output logic                         load_err
);

    localparam int AW  = $clog2(DEPTH);
    localparam int WW  = BYTE_W * WORD_BYTES;
    localparam int BCW = cnt_width(WORD_BYTES);

    logic [BYTE_W-1:0] rx_data_s;
    logic              rx_valid_s;
    logic              rx_ferr_s;

    loader_state_e     state_q, state_d;
    logic [BCW-1:0]    byte_cnt_q, byte_cnt_d;
    logic [AW-1:0]     word_cnt_q, word_cnt_d;
    logic [AW-1:0]     last_word_q, last_word_d;
    logic [WW-1:0]     shift_q, shift_d;
    logic              we_q, we_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [WW-1:0]     wdata_q, wdata_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              core_rstn_q, core_rstn_d;
    logic [WW-1:0]     asm_s;
    logic              byte_last_s;
`ifdef LOADER_CHECKSUM_EN
    logic [BYTE_W-1:0] csum_q, csum_d;
`endif

    uart_rx #(
        .CLK_PER_HALF_BIT(CLK_PER_HALF_BIT)
    ) u_uart_rx (
        .clk      (clk),
        .rstn     (rstn),
        .rxd      (rxd),
        .rx_data  (rx_data_s),
        .rx_valid (rx_valid_s),
        .rx_ferr  (rx_ferr_s)
    );

    // New byte enters at the top, so after WORD_BYTES bytes the first is the LSB.
    assign asm_s       = (shift_q >> BYTE_W) | (WW'(rx_data_s) << (WW - BYTE_W));
    assign byte_last_s = (byte_cnt_q == BCW'(WORD_BYTES - 1));

    // Loader FSM next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        word_cnt_d  = word_cnt_q;
        last_word_d = last_word_q;
        shift_d     = shift_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            ST_LEN: begin
                if (rx_ferr_s) begin
                    state_d = ST_ERR;
                end else if (rx_valid_s) begin
                    shift_d = asm_s;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data_s;
`endif
                    if (byte_last_s) begin
                        byte_cnt_d = BCW'(0);
                        if (64'(asm_s) > 64'(DEPTH)) begin
                            state_d = ST_ERR;
                        end else if (asm_s == WW'(0)) begin
                            state_d = ST_AFTER_PAYLOAD;
                        end else begin
                            state_d     = ST_DATA;
                            word_cnt_d  = AW'(0);
                            last_word_d = AW'(asm_s - WW'(1));
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end else begin
                    state_d = ST_LEN;
                end
            end
            ST_DATA: begin
                if (rx_ferr_s) begin
                    state_d = ST_ERR;
                end else if (rx_valid_s) begin
                    shift_d = asm_s;
`ifdef LOADER_CHECKSUM_EN
                    csum_d  = csum_q ^ rx_data_s;
`endif
                    if (byte_last_s) begin
                        byte_cnt_d = BCW'(0);
                        we_d       = 1'b1;
                        addr_d     = word_cnt_q;
                        wdata_d    = asm_s;
                        if (word_cnt_q == last_word_q) begin
                            state_d = ST_AFTER_PAYLOAD;
                        end else begin
                            word_cnt_d = word_cnt_q + AW'(1);
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + BCW'(1);
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (rx_ferr_s) begin
                    state_d = ST_ERR;
                end else if (rx_valid_s) begin
                    state_d = (rx_data_s == csum_q) ? ST_DONE : ST_ERR;
                end else begin
                    state_d = ST_CSUM;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_DONE;
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_ERR;
            end
        endcase
        done_d      = (state_d == ST_DONE);
        err_d       = (state_d == ST_ERR);
        core_rstn_d = (state_d == ST_DONE);
    end

    // Loader state, counters and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_LEN;
            byte_cnt_q  <= BCW'(0);
            word_cnt_q  <= AW'(0);
            last_word_q <= AW'(0);
            shift_q     <= WW'(0);
            we_q        <= 1'b0;
            addr_q      <= AW'(0);
            wdata_q     <= WW'(0);
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            core_rstn_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            word_cnt_q  <= word_cnt_d;
            last_word_q <= last_word_d;
            shift_q     <= shift_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            done_q      <= done_d;
            err_q       <= err_d;
            core_rstn_q <= core_rstn_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign core_rstn  = core_rstn_q;
    assign load_done  = done_q;
    assign load_err   = err_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: randomized UART byte streams checked
// against a stream-level reference model; honours LOADER_CHECKSUM_EN.
module tb_program_loader;

    localparam int HALF  = 4;
    localparam int DEPTH = 32;
    localparam int WB    = 4;

    typedef logic [7:0]  bq_t[$];
    typedef logic [31:0] wq_t[$];
    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        rxd = 1'b1;
    logic        imem_we;
    logic [4:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rstn;
    logic        load_done;
    logic        load_err;

    int  checks = 0;
    int  errors = 0;
    wr_t exp_q[$];

    program_loader #(
        .CLK_PER_HALF_BIT(HALF),
        .DEPTH(DEPTH),
        .WORD_BYTES(WB)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .rxd        (rxd),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rstn  (core_rstn),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rstn && imem_we) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write addr=%0d data=%h", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("write_addr", 64'(imem_addr), 64'(e.addr));
                chk("write_data", 64'(imem_wdata), 64'(e.data));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_bit(input logic b);
        rxd = b;
        repeat (2 * HALF) tick();
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(bad_stop ? 1'b0 : 1'b1);
        rxd = 1'b1;
        repeat ($urandom_range(0, 3) + (bad_stop ? 2 : 0)) tick();
    endtask

    task automatic do_reset();
        rxd = 1'b1;
        tick();
        rstn = 1'b0;
        #1;
        chk("rst_we", 64'(imem_we), 64'd0);
        chk("rst_addr", 64'(imem_addr), 64'd0);
        chk("rst_wdata", 64'(imem_wdata), 64'd0);
        chk("rst_core_rstn", 64'(core_rstn), 64'd0);
        chk("rst_done", 64'(load_done), 64'd0);
        chk("rst_err", 64'(load_err), 64'd0);
        repeat (3) tick();
        rstn = 1'b1;
        repeat (3) tick();
    endtask

    function automatic bq_t make_stream(input logic [31:0] n, input wq_t w);
        bq_t b;
        b = {};
        for (int i = 0; i < 4; i++) b.push_back(n[8*i +: 8]);
        foreach (w[k]) for (int i = 0; i < 4; i++) b.push_back(w[k][8*i +: 8]);
`ifdef LOADER_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            foreach (b[i]) x = x ^ b[i];
            b.push_back(x);
        end
`endif
        return b;
    endfunction

    function automatic wq_t rand_words(input int n);
        wq_t w;
        w = {};
        for (int i = 0; i < n; i++) w.push_back($urandom());
        return w;
    endfunction

    // Reference model: interprets the byte stream and queues the expected writes.
    task automatic model(input bq_t b, input int bad, output bit e_done, output bit e_err);
        logic [31:0] n;
        wr_t         wr;
        e_done = 1'b0;
        e_err  = 1'b1;
        if (bad >= 0 && bad < 4) return;
        n = {b[3], b[2], b[1], b[0]};
        if (n > DEPTH) return;
        for (int k = 0; k < int'(n); k++) begin
            if (bad >= 0 && bad <= 4 + 4*k + 3) return;
            wr.addr = k[4:0];
            wr.data = {b[4+4*k+3], b[4+4*k+2], b[4+4*k+1], b[4+4*k]};
            exp_q.push_back(wr);
        end
`ifdef LOADER_CHECKSUM_EN
        begin
            int         idx;
            logic [7:0] x;
            idx = 4 + 4*int'(n);
            if (bad == idx) return;
            x = 8'h00;
            for (int i = 0; i < idx; i++) x = x ^ b[i];
            if (b[idx] != x) return;
        end
`endif
        e_done = 1'b1;
        e_err  = 1'b0;
    endtask

    task automatic finish_check(input bit e_done, input bit e_err);
        for (int i = 0; i < 200; i++) begin
            if (load_done || load_err) break;
            tick();
        end
        repeat (4) tick();
        chk("load_done", 64'(load_done), 64'(e_done));
        chk("load_err", 64'(load_err), 64'(e_err));
        chk("core_rstn", 64'(core_rstn), 64'(e_done));
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run_load(input bq_t b, input int bad);
        bit e_done, e_err;
        model(b, bad, e_done, e_err);
        foreach (b[i]) send_byte(b[i], i == bad);
        finish_check(e_done, e_err);
    endtask

    initial begin
        bq_t b;
        wq_t w;

        do_reset();
        w = {32'h00100093, 32'h00100113, 32'h00200223};
        run_load(make_stream(32'd3, w), -1);

        do_reset();
        run_load(make_stream(32'd33, rand_words(2)), -1);

        do_reset();
        b = make_stream(32'd32, rand_words(32));
        for (int i = 0; i < 8; i++) b.push_back(8'($urandom()));
        run_load(b, -1);

        do_reset();
        run_load(make_stream(32'd3, rand_words(3)), 6);

        do_reset();
        run_load(make_stream(32'd0, rand_words(0)), -1);

        for (int it = 0; it < 3; it++) begin
            int n;
            n = $urandom_range(1, 6);
            do_reset();
            run_load(make_stream(32'(n), rand_words(n)), -1);
        end

        // Reset in the middle of word 2: words 0 and 1 are written, the rest is abandoned.
        do_reset();
        w = rand_words(3);
        b = make_stream(32'd3, w);
        begin
            wr_t wr;
            for (int k = 0; k < 2; k++) begin
                wr.addr = k[4:0];
                wr.data = w[k];
                exp_q.push_back(wr);
            end
        end
        for (int i = 0; i < 14; i++) send_byte(b[i], 1'b0);
        rxd = 1'b0;
        repeat (12) tick();
        chk("midreset_writes", 64'(exp_q.size()), 64'd0);
        do_reset();
        run_load(make_stream(32'd1, rand_words(1)), -1);

`ifdef LOADER_CHECKSUM_EN
        do_reset();
        run_load(make_stream(32'd1, {32'h00000013}), -1);
        do_reset();
        b = make_stream(32'd1, {32'h00000013});
        b[b.size()-1] = 8'h13;
        run_load(b, -1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
